// File: rtl/cariomart_cmd_rx.sv
// cariomart_cmd_rx: UART 8N1 receiver plus 5-byte drive-frame decoder.
// Frame: HDR_BYTE, steer, throttle, buttons, checksum (steer^throttle^buttons).
// Valid frames update STEER/THROTTLE/BUTTONS with a one-clock FRAME_VALID pulse;
// framing errors, checksum mismatches and inter-byte timeouts pulse FRAME_ERR.
// Internal handshake: byte_done_q is a one-clock strobe from the bit engine;
// the byte it refers to is shreg_q in that same cycle (shreg_q only changes in
// DATA, which cannot be re-entered within one clock of byte_done_q).
module cariomart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned TIMEOUT_CLKS = 40000,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UART_RXD,
  output logic [7:0] STEER,
  output logic [7:0] THROTTLE,
  output logic [7:0] BUTTONS,
  output logic       FRAME_VALID,
  output logic       FRAME_ERR,
  output logic       RX_BUSY
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BIT_HALF = 16'(CLKS_PER_BIT / 2);
  localparam int          TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} bit_state_t;
  typedef enum logic [2:0] {P_HDR, P_STEER, P_THR, P_BTN, P_CSUM} par_state_t;

  // synchronizer
  logic sync1_q, rxs_q;

  // bit engine
  bit_state_t  bstate_q, bstate_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        byte_done_q, byte_done_d;
  logic        ferr_q, ferr_d;

  // parser
  par_state_t  pstate_q, pstate_d;
  logic [7:0]  steer_sh_q, steer_sh_d;
  logic [7:0]  thr_sh_q, thr_sh_d;
  logic [7:0]  btn_sh_q, btn_sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        tmo_hit;
  logic [7:0]  steer_q, steer_d;
  logic [7:0]  thr_q, thr_d;
  logic [7:0]  btn_q, btn_d;
  logic        fv_q, fv_d;
  logic        fe_q, fe_d;

  // Two-flop synchronizer; idles high so reset cannot fake a start bit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= UART_RXD;
      rxs_q   <= sync1_q;
    end
  end

  // Bit engine next-state: mid-bit sampling, LSB-first shift, stop check.
  always_comb begin
    bstate_d    = bstate_q;
    bcnt_d      = bcnt_q;
    bidx_d      = bidx_q;
    shreg_d     = shreg_q;
    byte_done_d = 1'b0;
    ferr_d      = 1'b0;
    unique case (bstate_q)
      B_IDLE: begin
        if (!rxs_q) begin
          bcnt_d   = '0;
          bstate_d = B_START;
        end
      end
      B_START: begin
        if (bcnt_q == BIT_HALF) begin
          if (rxs_q) begin
            bstate_d = B_IDLE;          // glitch, not a start bit
          end else begin
            bcnt_d   = '0;
            bidx_d   = '0;
            bstate_d = B_DATA;
          end
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      B_DATA: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d  = '0;
          shreg_d = {rxs_q, shreg_q[7:1]};
          if (bidx_q == 3'd7) bstate_d = B_STOP;
          else                bidx_d   = bidx_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      B_STOP: begin
        if (bcnt_q == BIT_LAST) begin
          if (rxs_q) begin
            byte_done_d = 1'b1;
            bstate_d    = B_IDLE;
          end else begin
            ferr_d   = 1'b1;
            bstate_d = B_BREAK;         // wait out a held-low line
          end
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      B_BREAK: begin
        if (rxs_q) bstate_d = B_IDLE;
      end
      default: bstate_d = B_IDLE;
    endcase
  end

  // Bit engine registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bstate_q    <= B_IDLE;
      bcnt_q      <= '0;
      bidx_q      <= '0;
      shreg_q     <= '0;
      byte_done_q <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      bstate_q    <= bstate_d;
      bcnt_q      <= bcnt_d;
      bidx_q      <= bidx_d;
      shreg_q     <= shreg_d;
      byte_done_q <= byte_done_d;
      ferr_q      <= ferr_d;
    end
  end

  // Timeout fires only mid-frame; a byte_done in the same cycle takes priority.
  assign tmo_hit = (pstate_q != P_HDR) && (tmo_q == TMO_LAST);

  // Parser next-state: frame assembly, checksum, error reporting.
  always_comb begin
    pstate_d   = pstate_q;
    steer_sh_d = steer_sh_q;
    thr_sh_d   = thr_sh_q;
    btn_sh_d   = btn_sh_q;
    tmo_d      = tmo_q;
    steer_d    = steer_q;
    thr_d      = thr_q;
    btn_d      = btn_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    if (byte_done_q) begin
      tmo_d = '0;
      unique case (pstate_q)
        P_HDR: begin
          if (shreg_q == HDR_BYTE) pstate_d = P_STEER;
        end
        P_STEER: begin
          steer_sh_d = shreg_q;
          pstate_d   = P_THR;
        end
        P_THR: begin
          thr_sh_d = shreg_q;
          pstate_d = P_BTN;
        end
        P_BTN: begin
          btn_sh_d = shreg_q;
          pstate_d = P_CSUM;
        end
        P_CSUM: begin
          if (shreg_q == (steer_sh_q ^ thr_sh_q ^ btn_sh_q)) begin
            steer_d = steer_sh_q;
            thr_d   = thr_sh_q;
            btn_d   = btn_sh_q;
            fv_d    = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
          pstate_d = P_HDR;
        end
        default: pstate_d = P_HDR;
      endcase
    end else if (ferr_q || tmo_hit) begin
      pstate_d = P_HDR;
      tmo_d    = '0;
      fe_d     = 1'b1;
    end else if (pstate_q != P_HDR) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = '0;
    end
  end

  // Parser registers and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pstate_q   <= P_HDR;
      steer_sh_q <= '0;
      thr_sh_q   <= '0;
      btn_sh_q   <= '0;
      tmo_q      <= '0;
      steer_q    <= 8'h80;
      thr_q      <= 8'h00;
      btn_q      <= 8'h00;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      pstate_q   <= pstate_d;
      steer_sh_q <= steer_sh_d;
      thr_sh_q   <= thr_sh_d;
      btn_sh_q   <= btn_sh_d;
      tmo_q      <= tmo_d;
      steer_q    <= steer_d;
      thr_q      <= thr_d;
      btn_q      <= btn_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
    end
  end

  assign STEER       = steer_q;
  assign THROTTLE    = thr_q;
  assign BUTTONS     = btn_q;
  assign FRAME_VALID = fv_q;
  assign FRAME_ERR   = fe_q;
  assign RX_BUSY     = (bstate_q != B_IDLE);

endmodule

// File: tb/tb_cariomart_cmd_rx.sv
// Bench for cariomart_cmd_rx: serial driver, streaming frame model feeding an
// expected-event queue, and a monitor that pops on every FRAME_VALID/FRAME_ERR.
module tb_cariomart_cmd_rx;

  localparam int         CPB = 16;
  localparam int         TMO = 1000;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int         W   = 25;   // {err, steer, throttle, buttons}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] steer, thr, btn;
  logic       fv, fe, busy;

  always #5 clk = ~clk;

  cariomart_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO),
    .HDR_BYTE    (HDR)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .UART_RXD   (rxd),
    .STEER      (steer),
    .THROTTLE   (thr),
    .BUTTONS    (btn),
    .FRAME_VALID(fv),
    .FRAME_ERR  (fe),
    .RX_BUSY    (busy)
  );

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] frm[$];
  logic [7:0] m_steer = 8'h80;
  logic [7:0] m_thr   = 8'h00;
  logic [7:0] m_btn   = 8'h00;
  logic [W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference model: a frame is a header followed by four bytes; the last
  // must equal the XOR of the middle three.
  task automatic model_byte(input logic [7:0] b);
    if (frm.size() == 0) begin
      if (b == HDR) frm.push_back(b);
    end else begin
      frm.push_back(b);
      if (frm.size() == 5) begin
        if ((frm[1] ^ frm[2] ^ frm[3]) == frm[4]) begin
          m_steer = frm[1];
          m_thr   = frm[2];
          m_btn   = frm[3];
          exp_q.push_back({1'b0, m_steer, m_thr, m_btn});
        end else begin
          exp_q.push_back({1'b1, m_steer, m_thr, m_btn});
        end
        frm.delete();
      end
    end
  endtask

  task automatic model_abort();
    exp_q.push_back({1'b1, m_steer, m_thr, m_btn});
    frm.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (fv && fe) begin
        n_tests++;
        n_fail++;
        $display("FAIL exclusive_pulses: got valid=1 err=1 expected at most one");
      end
      if (fv || fe) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got valid=%0b err=%0b expected no event", fv, fe);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_event", {7'd0, fe, steer, thr, btn}, {7'd0, mon_e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(CPB);
    end
    rxd = stop_bit;
    wait_clks(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    drive_byte(b, 1'b1);
    rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] t,
                            input logic [7:0] bt, input logic [7:0] c);
    send_byte(HDR); wait_clks($urandom_range(0, 40));
    send_byte(s);   wait_clks($urandom_range(0, 40));
    send_byte(t);   wait_clks($urandom_range(0, 40));
    send_byte(bt);  wait_clks($urandom_range(0, 40));
    send_byte(c);   wait_clks($urandom_range(0, 40));
  endtask

  task automatic silence_long();
    if (frm.size() != 0) model_abort();
    wait_clks(TMO + 100);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      wait_clks(1);
      k++;
    end
    wait_clks(3 * CPB);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [7:0] rs, rt, rb, rc;
  initial begin
    wait_clks(3);
    check("rst_steer", steer, 8'h80);
    check("rst_thr", thr, 8'h00);
    check("rst_btn", btn, 8'h00);
    check("rst_flags", {fv, fe, busy}, 3'b000);
    rst = 1'b0;
    wait_clks(5);

    // Basic valid frame.
    send_frame(8'h10, 8'h7F, 8'h03, 8'h6C);
    drain();
    check("f1_steer", steer, 8'h10);
    check("f1_thr", thr, 8'h7F);
    check("f1_btn", btn, 8'h03);

    // Bad checksum: outputs hold, then a good frame.
    send_frame(8'h20, 8'h30, 8'h40, 8'h51);
    drain();
    check("bad_hold_steer", steer, 8'h10);
    send_frame(8'h21, 8'h31, 8'h41, 8'h21 ^ 8'h31 ^ 8'h41);
    drain();
    check("f2_steer", steer, 8'h21);

    // Line noise then a frame with header value as payload.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    send_frame(8'hA5, 8'h00, 8'h01, 8'hA4);
    drain();
    check("hdr_payload", {steer, thr, btn}, 24'hA50001);

    // Short low glitch on an idle line.
    rxd = 1'b0;
    wait_clks(CPB / 4);
    check("glitch_busy_rise", busy, 1'b1);
    rxd = 1'b1;
    wait_clks(CPB / 2 + 3);
    check("glitch_busy_fall", busy, 1'b0);
    wait_clks(2 * CPB);

    // Framing error followed by a held-low line.
    model_abort();
    drive_byte(8'h5A, 1'b0);
    wait_clks(5 * CPB);
    check("break_busy", busy, 1'b1);
    rxd = 1'b1;
    wait_clks(4);
    check("break_release", busy, 1'b0);
    drain();
    send_frame(8'h33, 8'h44, 8'h55, 8'h22);
    drain();
    check("after_break", {steer, thr, btn}, 24'h334455);

    // Inter-byte timeout.
    send_byte(HDR);
    send_byte(8'h20);
    silence_long();
    drain();
    check("tmo_hold", {steer, thr, btn}, 24'h334455);

    // Reset in the middle of a byte of a new frame.
    send_byte(HDR);
    rxd = 1'b0;
    wait_clks(2 * CPB + CPB / 2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {steer, thr, btn}, 24'h800000);
    check("async_rst_busy", busy, 1'b0);
    rxd = 1'b1;
    frm.delete();
    m_steer = 8'h80; m_thr = 8'h00; m_btn = 8'h00;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(5);
    send_frame(8'h66, 8'h77, 8'h88, 8'h66 ^ 8'h77 ^ 8'h88);
    drain();
    check("post_rst_frame", {steer, thr, btn}, 24'h667788);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      rs = 8'($urandom); rt = 8'($urandom); rb = 8'($urandom);
      rc = rs ^ rt ^ rb;
      case ($urandom_range(0, 7))
        6: send_frame(rs, rt, rb, rc ^ 8'($urandom_range(1, 255)));
        7: begin
          send_byte(8'($urandom));
          wait_clks($urandom_range(0, 40));
        end
        default: send_frame(rs, rt, rb, rc);
      endcase
    end
    silence_long();
    drain();
    check("final_outputs", {steer, thr, btn}, {m_steer, m_thr, m_btn});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
